// File: rtl/game_ctrl_if.sv
// Handshake bundle between the game controller, its buttons and the bird sprite stage.
interface game_ctrl_if #(
    parameter int unsigned SCORE_W = 10
);
    logic               btn_flap;
    logic               btn_down;
    logic               btn_start;
    logic               out_of_bound;
    logic               collide;
    logic               pass_pipe;
    logic [1:0]         state;
    logic               up;
    logic               down;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] best_score;
    logic               new_best;

    modport master (
        output btn_flap, btn_down, btn_start, out_of_bound, collide, pass_pipe,
        input  state, up, down, score, best_score, new_best
    );

    modport slave (
        input  btn_flap, btn_down, btn_start, out_of_bound, collide, pass_pipe,
        output state, up, down, score, best_score, new_best
    );
endinterface

// File: rtl/game_ctrl.sv
// Frame-rate game FSM: turns button presses into per-frame up/down commands and keeps scores.
module game_ctrl #(
    parameter int unsigned FLAP_FRAMES = 8,
    parameter int unsigned OVER_HOLD   = 60,
    parameter int unsigned SCORE_W     = 10
) (
    input  logic       frame_clk,
    input  logic       rstn,
    game_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_OVER    = 2'd2;

    localparam logic [7:0]         FLAP_LD   = 8'(FLAP_FRAMES);
    localparam logic [7:0]         HOLD_MAX  = 8'(OVER_HOLD);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [1:0]         r_state;
    logic               r_up;
    logic               r_down;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_best;
    logic               r_new_best;
    logic [7:0]         r_flap_cnt;
    logic [7:0]         r_hold_cnt;
    logic               r_flap_q;
    logic               r_down_q;
    logic               r_start_q;

    logic       w_flap_press;
    logic       w_start_press;
    logic       w_dead;
    logic [7:0] w_flap_next;
    logic       w_up_next;

    assign w_flap_press  = bus.btn_flap  & ~r_flap_q;
    assign w_start_press = bus.btn_start & ~r_start_q;
    assign w_dead        = bus.out_of_bound | bus.collide;

    // A press reloads the counter outright, so overlapping flaps never accumulate.
    assign w_flap_next = w_flap_press          ? FLAP_LD :
                         (r_flap_cnt != 8'd0)  ? r_flap_cnt - 8'd1 : '0;
    assign w_up_next   = (w_flap_next != 8'd0);

    always_ff @(posedge frame_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_up       <= 1'b0;
            r_down     <= 1'b0;
            r_score    <= '0;
            r_best     <= '0;
            r_new_best <= 1'b0;
            r_flap_cnt <= '0;
            r_hold_cnt <= '0;
            r_flap_q   <= 1'b0;
            r_down_q   <= 1'b0;
            r_start_q  <= 1'b0;
        end else begin
            r_flap_q  <= bus.btn_flap;
            r_down_q  <= bus.btn_down;
            r_start_q <= bus.btn_start;
            case (r_state)
                ST_IDLE: begin
                    r_up   <= 1'b0;
                    r_down <= 1'b0;
                    if (w_start_press | w_flap_press) begin
                        r_state    <= ST_RUNNING;
                        r_score    <= '0;
                        r_new_best <= 1'b0;
                        r_flap_cnt <= '0;
                    end
                end
                ST_RUNNING: begin
                    // Death wins over a same-frame pass; best is judged on the pre-death score.
                    if (w_dead) begin
                        r_state    <= ST_OVER;
                        r_hold_cnt <= '0;
                        r_up       <= 1'b0;
                        r_down     <= 1'b0;
                        r_flap_cnt <= '0;
                        if (r_score > r_best) begin
                            r_best     <= r_score;
                            r_new_best <= 1'b1;
                        end
                    end else begin
                        r_flap_cnt <= w_flap_next;
                        r_up       <= w_up_next;
                        r_down     <= bus.btn_down & ~w_up_next;
                        if (bus.pass_pipe && (r_score != SCORE_MAX))
                            r_score <= r_score + 1'b1;
                    end
                end
                ST_OVER: begin
                    r_up   <= 1'b0;
                    r_down <= 1'b0;
                    if (r_hold_cnt != HOLD_MAX)
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (w_start_press && (r_hold_cnt == HOLD_MAX)) begin
                        r_state    <= ST_IDLE;
                        r_new_best <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_up       <= 1'b0;
                    r_down     <= 1'b0;
                    r_score    <= '0;
                    r_best     <= '0;
                    r_new_best <= 1'b0;
                    r_flap_cnt <= '0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.state      = r_state;
    assign bus.up         = r_up;
    assign bus.down       = r_down;
    assign bus.score      = r_score;
    assign bus.best_score = r_best;
    assign bus.new_best   = r_new_best;
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Frame-rate game controller that sits directly upstream of the bird sprite stage. It runs the IDLE/RUNNING/OVER game state machine and converts the raw flap, dive and start buttons into the per-frame `up`/`down` motion commands the bird stage consumes. It ends the game on bird out-of-bound or pipe collision, and keeps the current and best scores.

Parameters:
FLAP_FRAMES, 8, number of frames `up` stays asserted after one flap press (1..255)
OVER_HOLD, 60, minimum frames spent in OVER before a start press is accepted (1..255)
SCORE_W, 10, width of the score counters

Ports:
frame_clk  input  1  frame-rate clock, one tick per video frame
rstn  input  1  asynchronous active-low reset
btn_flap  input  1  flap button level, debounced, synchronous to frame_clk
btn_down  input  1  dive button level, debounced, synchronous to frame_clk
btn_start  input  1  start/restart button level, debounced, synchronous to frame_clk
out_of_bound  input  1  bird has left the play area, from the bird stage
collide  input  1  bird/pipe overlap detected this frame
pass_pipe  input  1  single-frame pulse: the bird has cleared a pipe pair
state  output  2  game state: 2'd0 IDLE, 2'd1 RUNNING, 2'd2 OVER (2'd3 unused)
up  output  1  bird rise command for this frame
down  output  1  bird dive command for this frame
score  output  SCORE_W  pipes passed in the current or last game
best_score  output  SCORE_W  highest score since reset
new_best  output  1  high while in OVER if the last game set a new best

Behaviour:
- Reset: rstn is asynchronous and active-low; the clock is frame_clk.
- Reset values: state=IDLE, up=0, down=0, score=0, best_score=0, new_best=0; internal flap_cnt=0, hold_cnt=0, button history registers=0.
- Edge detect: each button has a history register. A press is level=1 while history=0, so it fires on exactly one frame per press. Holding a button gives no repeats.
- All outputs are registered. An input sampled at edge N affects outputs after edge N, and the bird stage consumes them at edge N+1.
- IDLE:
  - A start press or a flap press moves to RUNNING.
  - On that transition: score=0, new_best=0, flap_cnt=0.
  - up=0 and down=0 throughout IDLE.
- RUNNING, flap:
  - A flap press loads flap_cnt=FLAP_FRAMES.
  - Otherwise, if flap_cnt!=0, it decrements by 1.
  - A press while flap_cnt is non-zero reloads it to FLAP_FRAMES; there is no accumulation.
- RUNNING, motion outputs:
  - up = (next flap_cnt != 0).
  - down = btn_down & ~up; flap has priority over dive.
- RUNNING, end of game:
  - If out_of_bound | collide, move to OVER.
  - On that edge: hold_cnt=0, up=0, down=0, flap_cnt=0.
  - If score > best_score, set best_score=score and new_best=1.
- RUNNING, scoring:
  - pass_pipe increments score, saturating at 2^SCORE_W-1.
  - If pass_pipe arrives in the same frame as death, death wins and the pass is not counted.
- OVER:
  - hold_cnt increments, saturating at OVER_HOLD.
  - A start press with hold_cnt==OVER_HOLD moves to IDLE; score stays visible and new_best is cleared.
  - Start presses before the hold expires are ignored; they are not queued.
  - Flap presses are ignored in OVER.
- Illegal state 2'd3 returns to IDLE on the next edge with outputs at their reset values.
- Reset mid-game forces the reset values immediately (asynchronously); best_score is lost.
- Width rules:
  - flap_cnt and hold_cnt are 8 bits.
  - Comparisons are unsigned.
  - The score compare for best uses the pre-death score register.

Test Plan:
1. Reset, then hold btn_start high for 5 frames -> state goes IDLE→RUNNING after the first edge only; score=0; up=0.
2. RUNNING, one btn_flap press with FLAP_FRAMES=8 -> up=1 for exactly 8 consecutive frames, then 0. A second press on frame 5 -> up stays 1 until 8 frames after that press (12 total).
3. RUNNING, btn_down held while flapping -> down=0 while up=1, and down=1 on the first frame up drops.
4. Five pass_pipe pulses, then collide together with a 6th pass_pipe -> score=5, state=OVER, best_score=5, new_best=1. Next game dies at score 3 -> best_score stays 5, new_best=0.
5. OVER with OVER_HOLD=60: start pressed at hold frame 10 → still OVER; press at frame 60+ → IDLE next edge. Flap in OVER → no effect.
6. SCORE_W=4: 20 pass_pipe pulses → score saturates at 15. Assert rstn low mid-RUNNING → all outputs 0 immediately, state=IDLE.
